// File: rtl/sram_like_mux_bridge.sv
// Serialises NCH sram-style requesters onto one sram_like master, one transaction in flight.
// Define RR_ARB_EN for round-robin arbitration; otherwise channel 0 has fixed highest priority.
module sram_like_mux_bridge #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    ch_en_i,
  input  logic [NCH*4-1:0]  ch_wen_i,
  input  logic [NCH*AW-1:0] ch_addr_i,
  input  logic [NCH*DW-1:0] ch_wdata_i,
  output logic [NCH*DW-1:0] ch_rdata_o,
  output logic [NCH-1:0]    ch_stall_o,
  output logic [NCH-1:0]    ch_err_o,
  output logic              stall_o,
  output logic              req_o,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [AW-1:0]     addr_o,
  output logic [DW-1:0]     wdata_o,
  input  logic [DW-1:0]     rdata_i,
  input  logic              addr_ok_i,
  input  logic              data_ok_i
);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic [NCH-1:0]    pend_q, err_q;
  logic [GW-1:0]     g_q;
  logic [NCH*DW-1:0] rdata_q;

  logic [NCH-1:0]    legal, rem, g_oh;
  logic [GW-1:0]     gnt_idle, gnt_rem;
  logic [3:0]        sel_wen;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [1:0]        sel_size;
  logic              done;

  // Returns {wen_ok, size}.
  function automatic logic [2:0] wen_decode(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_decode = 3'b100;
      4'b0011, 4'b1100:                   wen_decode = 3'b101;
      4'b1111, 4'b0000:                   wen_decode = 3'b110;
      default:                            wen_decode = 3'b000;
    endcase
  endfunction

`ifdef RR_ARB_EN
  // g_q holds the last granted index, so it serves as the round-robin pointer.
  function automatic logic [GW-1:0] pick(input logic [NCH-1:0] m, input logic [GW-1:0] last);
    int best, dist;
    pick = '0;
    best = int'(NCH);
    for (int i = 0; i < int'(NCH); i++) begin
      dist = (i + int'(NCH) - 1 - int'(last)) % int'(NCH);
      if (m[i] && dist < best) begin
        best = dist;
        pick = GW'(i);
      end
    end
  endfunction

  assign gnt_idle = pick(legal, g_q);
  assign gnt_rem  = pick(rem, g_q);
`else
  function automatic logic [GW-1:0] pick(input logic [NCH-1:0] m);
    pick = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (m[i]) pick = GW'(i);
    end
  endfunction

  assign gnt_idle = pick(legal);
  assign gnt_rem  = pick(rem);
`endif

  always_comb begin
    logic [2:0] dec;
    logic [1:0] lo;
    logic       mis;
    legal = '0;
    dec   = '0;
    lo    = '0;
    mis   = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      dec      = wen_decode(ch_wen_i[i*4 +: 4]);
      lo       = ch_addr_i[i*AW +: 2];
      mis      = (dec[1:0] == 2'd1 && lo[0]) || (dec[1:0] == 2'd2 && lo != 2'b00);
      legal[i] = ch_en_i[i] && dec[2] && !mis;
    end
  end

  always_comb begin
    logic [2:0] sel_dec;
    sel_wen   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    g_oh      = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (GW'(i) == g_q) begin
        sel_wen   = ch_wen_i[i*4 +: 4];
        sel_addr  = ch_addr_i[i*AW +: AW];
        sel_wdata = ch_wdata_i[i*DW +: DW];
        g_oh[i]   = 1'b1;
      end
    end
    sel_dec  = wen_decode(sel_wen);
    sel_size = sel_dec[1:0];
    rem      = pend_q & ~g_oh;
  end

  // An addr_ok with data_ok in the same REQ cycle completes without visiting WAIT.
  assign done = (state_q == StReq && addr_ok_i && data_ok_i) || (state_q == StWait && data_ok_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      err_q   <= '0;
      g_q     <= '0;
      rdata_q <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        StIdle: begin
          pend_q <= legal;
          err_q  <= ch_en_i & ~legal;
          if (|legal) begin
            g_q     <= gnt_idle;
            state_q <= StReq;
          end
        end
        StReq: if (addr_ok_i && !data_ok_i) state_q <= StWait;
        default: ;
      endcase
      if (done) begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (g_oh[i] && sel_wen == 4'b0000) rdata_q[i*DW +: DW] <= rdata_i;
        end
        pend_q <= rem;
        if (|rem) begin
          g_q     <= gnt_rem;
          state_q <= StReq;
        end else begin
          state_q <= StIdle;
        end
      end
    end
  end

  assign req_o      = (state_q == StReq);
  assign wr_o       = req_o & (|sel_wen);
  assign size_o     = req_o ? sel_size : 2'b00;
  assign addr_o     = req_o ? sel_addr : '0;
  assign wdata_o    = req_o ? sel_wdata : '0;
  assign ch_stall_o = pend_q;
  assign stall_o    = |pend_q;
  assign ch_err_o   = err_q;
  assign ch_rdata_o = rdata_q;

endmodule

// File: tb/tb_sram_like_mux_bridge.sv
// Scoreboarded random bench for sram_like_mux_bridge with a behavioural bus responder.
module tb_sram_like_mux_bridge;
  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    ch_en_i;
  logic [NCH*4-1:0]  ch_wen_i;
  logic [NCH*AW-1:0] ch_addr_i;
  logic [NCH*DW-1:0] ch_wdata_i;
  logic [NCH*DW-1:0] ch_rdata_o;
  logic [NCH-1:0]    ch_stall_o, ch_err_o;
  logic              stall_o, req_o, wr_o;
  logic [1:0]        size_o;
  logic [AW-1:0]     addr_o;
  logic [DW-1:0]     wdata_o, rdata_i;
  logic              addr_ok_i, data_ok_i;

  always #5 clk_i = ~clk_i;

  sram_like_mux_bridge #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_en_i(ch_en_i), .ch_wen_i(ch_wen_i),
    .ch_addr_i(ch_addr_i), .ch_wdata_i(ch_wdata_i), .ch_rdata_o(ch_rdata_o),
    .ch_stall_o(ch_stall_o), .ch_err_o(ch_err_o), .stall_o(stall_o), .req_o(req_o),
    .wr_o(wr_o), .size_o(size_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
  } bus_t;

  bus_t           bus_q[$];
  logic [NCH-1:0] err_q[$];
  logic [31:0]    exp_rd [NCH];
  int             checks = 0;
  int             failures = 0;
  int             mode = 0;  // 0 random, 1 zero-wait, 2 addr_ok after 5 cycles, 3 never data_ok
  bit             stray = 1'b0;
`ifdef RR_ARB_EN
  int             last_g = 0;
`endif

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    return 32'hDEADBEEF ^ ((a - 32'h100) * 32'h9E3779B1);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  // -1 marks an illegal byte-enable pattern.
  function automatic int model_size(input logic [3:0] wen);
    if (wen == 4'h0 || wen == 4'hF) return 2;
    if ($countones(wen) == 1) return 0;
    if (wen == 4'b0011 || wen == 4'b1100) return 1;
    return -1;
  endfunction

  initial begin : responder
    bit          busy;
    bit          acc;
    int          cnt;
    int          waited;
    logic [31:0] cap;
    busy = 0; cnt = 0; waited = 0; cap = '0;
    addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      addr_ok_i = 1'b0;
      data_ok_i = 1'b0;
      rdata_i   = $urandom;
      if (rst_i) begin
        busy = 0;
        waited = 0;
      end else if (stray) begin
        data_ok_i = 1'b1;
      end else if (busy) begin
        if (mode != 3) begin
          if (cnt == 0) begin
            data_ok_i = 1'b1;
            rdata_i   = resp_data(cap);
            busy      = 0;
          end else cnt--;
        end
      end else if (req_o) begin
        case (mode)
          0:       acc = 1'($urandom_range(0, 1));
          2:       acc = (waited == 5);
          default: acc = 1'b1;
        endcase
        if (!acc) begin
          waited++;
          if (mode == 0 && $urandom_range(0, 7) == 0) data_ok_i = 1'b1;
        end else begin
          waited    = 0;
          addr_ok_i = 1'b1;
          cap       = addr_o;
          if (mode == 0 && $urandom_range(0, 3) == 0) begin
            data_ok_i = 1'b1;
            rdata_i   = resp_data(cap);
          end else begin
            busy = 1;
            cnt  = (mode == 0) ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end else begin
        waited = 0;
      end
    end
  end

  initial begin : monitor
    bit   pend_prev;
    bus_t prev, cur, e;
    pend_prev = 0;
    prev = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        pend_prev = 0;
      end else begin
        cur = '{addr: addr_o, wdata: wdata_o, wr: wr_o, size: size_o};
        if (req_o) begin
          if (pend_prev) chk("req_stable", cur, prev);
          if (addr_ok_i) begin
            if (bus_q.size() == 0) fail_now("unexpected_req");
            else begin
              e = bus_q.pop_front();
              chk("bus_txn", cur, e);
            end
            pend_prev = 0;
          end else pend_prev = 1;
          prev = cur;
        end else begin
          chk("idle_outputs", cur, '0);
          pend_prev = 0;
        end
        if (ch_err_o != '0) begin
          if (err_q.size() == 0) fail_now("unexpected_err");
          else chk("ch_err", ch_err_o, err_q.pop_front());
        end
      end
    end
  end

  task automatic issue_batch(input logic [NCH-1:0] en, input logic [4*NCH-1:0] wen,
                             input logic [32*NCH-1:0] addr, input logic [32*NCH-1:0] wd,
                             output int cyc);
    logic [NCH-1:0] legal;
    int             sz [NCH];
    int             start, c;
    bus_t           e;
    legal = '0;
    for (int i = 0; i < NCH; i++) begin
      sz[i] = model_size(wen[i*4 +: 4]);
      if (en[i] && sz[i] >= 0 && (int'(addr[i*32 +: 2]) % (1 << sz[i])) == 0) legal[i] = 1'b1;
    end
    if ((en & ~legal) != '0) err_q.push_back(en & ~legal);
`ifdef RR_ARB_EN
    start = last_g + 1;
`else
    start = 0;
`endif
    for (int k = 0; k < NCH; k++) begin
      c = (start + k) % NCH;
      if (legal[c]) begin
        e.addr  = addr[c*32 +: 32];
        e.wdata = wd[c*32 +: 32];
        e.wr    = (wen[c*4 +: 4] != 4'h0);
        e.size  = 2'(sz[c]);
        bus_q.push_back(e);
        if (wen[c*4 +: 4] == 4'h0) exp_rd[c] = resp_data(addr[c*32 +: 32]);
`ifdef RR_ARB_EN
        last_g = c;
`endif
      end
    end
    ch_en_i = en; ch_wen_i = wen; ch_addr_i = addr; ch_wdata_i = wd;
    @(posedge clk_i);
    #1;
    chk("stall_capture", ch_stall_o, legal);
    cyc = 0;
    while (stall_o === 1'b1 && cyc < 300) begin
      cyc++;
      @(posedge clk_i);
      #1;
    end
    if (cyc >= 300) fail_now("stall_timeout");
    for (int i = 0; i < NCH; i++) chk("rdata_hold", ch_rdata_o[i*32 +: 32], exp_rd[i]);
    ch_en_i = '0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [NCH-1:0]    en;
    logic [4*NCH-1:0]  wen;
    logic [32*NCH-1:0] addr, wd;
    logic [31:0]       r;
    logic [3:0]        wtab [8];
    int                cyc;
    wtab = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    rst_i = 1'b1; ch_en_i = '0; ch_wen_i = '0; ch_addr_i = '0; ch_wdata_i = '0;
    for (int i = 0; i < NCH; i++) exp_rd[i] = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_req", req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", ch_err_o, 0);
    chk("rst_rdata", ch_rdata_o, 0);

    // Zero-wait single read: stall visible for exactly two cycles.
    mode = 1;
    en = 3'b001; wen = '0; addr = '0; wd = {3{32'h1234_5678}};
    addr[31:0] = 32'h100;
    issue_batch(en, wen, addr, wd, cyc);
    chk("stall_cycles", cyc, 2);
    chk("rdata0_value", ch_rdata_o[31:0], 32'hDEADBEEF);

    // Half write on ch0 plus read on ch1 together.
    mode = 0;
    en = 3'b011; wen = '0; addr = '0; wd = {32'h0, 32'hCAFE_0001, 32'hABCD_1234};
    wen[3:0] = 4'b0011; addr[31:0] = 32'h102; addr[63:32] = 32'h200;
    issue_batch(en, wen, addr, wd, cyc);

    // Illegal wen on ch1, misaligned word read on ch0.
    en = 3'b011; wen = '0; addr = '0;
    wen[7:4] = 4'b0101; addr[31:0] = 32'h3;
    issue_batch(en, wen, addr, wd, cyc);
    chk("err_no_stall", cyc, 0);
    @(posedge clk_i);
    #1;

    // Address phase held off for five cycles.
    mode = 2;
    en = 3'b100; wen = '0; addr = '0; wd = {32'h5A5A_A5A5, 64'h0};
    wen[11:8] = 4'hF; addr[95:64] = 32'h400;
    issue_batch(en, wen, addr, wd, cyc);
    chk("hold_stall_len", cyc, 7);

    mode = 0;
    for (int b = 0; b < 150; b++) begin
      for (int i = 0; i < NCH; i++) begin
        en[i] = 1'($urandom_range(0, 1));
        wen[i*4 +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : wtab[$urandom_range(0, 7)];
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        addr[i*32 +: 32] = r;
        wd[i*32 +: 32] = $urandom;
      end
      issue_batch(en, wen, addr, wd, cyc);
    end

    // Two back-to-back batches with every channel pending.
    for (int b = 0; b < 2; b++) begin
      en = '1; wen = '0;
      for (int i = 0; i < NCH; i++) begin
        addr[i*32 +: 32] = 32'h1000 * (b + 1) + 32'h10 * i;
        wd[i*32 +: 32] = $urandom;
      end
      issue_batch(en, wen, addr, wd, cyc);
    end

    // Reset while the bus is in its data phase.
    mode = 3;
    en = 3'b001; wen = '0; addr = '0; addr[31:0] = 32'h100;
    begin
      bus_t e;
      e = '{addr: 32'h100, wdata: wd[31:0], wr: 1'b0, size: 2'd2};
      bus_q.push_back(e);
`ifdef RR_ARB_EN
      last_g = 0;
`endif
    end
    ch_en_i = en; ch_wen_i = wen; ch_addr_i = addr; ch_wdata_i = wd;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("wait_stall", ch_stall_o, 3'b001);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_req", req_o, 0);
    chk("rst_async_stall", stall_o, 0);
    chk("rst_async_rdata", ch_rdata_o, 0);
    for (int i = 0; i < NCH; i++) exp_rd[i] = '0;
    ch_en_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    mode = 1;
    stray = 1'b1;
    @(posedge clk_i);
    #2 stray = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
      chk("stray_stall", stall_o, 0);
      chk("stray_rdata", ch_rdata_o, 0);
      chk("stray_err", ch_err_o, 0);
    end
    en = 3'b010; wen = '0; addr = '0; addr[63:32] = 32'h800;
    issue_batch(en, wen, addr, wd, cyc);

    repeat (4) @(posedge clk_i);
    #1;
    chk("bus_q_empty", bus_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
